barcode_frame_ctrl: RTL and testbench
=====================================

BARCODE_FRAME_CTRL -- requirements
Module: barcode_frame_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- MIN_DIGITS, 8, fewest digits accepted in a frame.
- MAX_DIGITS, 13, most digits accepted in a frame.
- TIMEOUT_CYCLES, 500000, idle clocks allowed between bytes inside a frame.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, one clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- code_bcd  out  52  packed BCD digits of the barcode.
- code_len  out  4  digit count of code_bcd.
- code_valid  out  1  frame available.
- code_ready  in  1  consumer accepts the frame.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  error cause, meaningful only while err_valid=1.

Function
REQ-003 Byte classes SHALL be: digit 0x30-0x39; terminator 0x0D or 0x0A; anything else is "other".
REQ-004 States SHALL be IDLE, COLLECT, CHECK (present only with the macro), HOLD and DISCARD.
REQ-005 IDLE transitions SHALL be:
- terminator: ignored (absorbs CR/LF pairs).
- digit: code_bcd set to all 0xF, digit stored at nibble 0, code_len=1, go to COLLECT.
- other: err 1 (BADCHAR), go to DISCARD.
REQ-006 In COLLECT, a digit SHALL be stored at code_bcd[4*code_len+3:4*code_len] and code_len incremented.
- If code_len==MAX_DIGITS already: err 2 (OVERFLOW), go to DISCARD, byte not stored.
REQ-007 In COLLECT, a terminator SHALL be handled by length:
- code_len<MIN_DIGITS: err 3 (SHORT), go to IDLE.
- Otherwise: go to HOLD, or to CHECK when the macro is defined.
- In COLLECT, an "other" byte gives err 1 and goes to DISCARD.
REQ-008 DISCARD SHALL drop every byte until a terminator, then go to IDLE with no error.
REQ-009 A timeout counter SHALL clear on every rx_valid and increment otherwise.
- Reaching TIMEOUT_CYCLES in COLLECT: err 4 (TIMEOUT), go to IDLE.
- Reaching TIMEOUT_CYCLES in DISCARD: go to IDLE silently.
- In other states the counter SHALL be held at 0.
REQ-010 In HOLD, code_valid SHALL be 1 and code_bcd/code_len SHALL stay stable until code_valid&&code_ready.
- The state after the handshake SHALL be IDLE; code_valid is 0 the next cycle.
REQ-011 An rx_valid in HOLD or CHECK SHALL drop the byte and pulse err 5 (OVERRUN) without changing state, including when it coincides with the handshake cycle.
REQ-012 code_valid SHALL rise 1 cycle after the terminator's rx_valid without the macro, and 2 cycles after with it.
REQ-013 err_valid SHALL be registered, one cycle wide, and asserted the cycle after the causing event; err_code SHALL be 0 when err_valid=0.
REQ-014 Digit nibble i SHALL be the i-th digit received, counting from 0; unused nibbles SHALL read 0xF.

Reset
REQ-015 rst_n low SHALL immediately set:
- state=IDLE, timeout counter=0;
- code_bcd=all ones, code_len=0;
- code_valid=0, err_valid=0, err_code=0.
REQ-016 A reset mid-frame or in HOLD SHALL discard the frame, with no err pulse after release.
REQ-017 The first byte after rst_n rises SHALL be processed as in IDLE.

Configuration
REQ-018 With BARCODE_CHECKSUM_EN defined, COLLECT SHALL go to CHECK on an accepted terminator; CHECK SHALL last one cycle.
REQ-019 In CHECK, for code_len 13 or 8 the block SHALL compute the EAN check digit:
- Take all digits except the last; weights are 3 on the digit nearest the check digit, alternating 3/1 leftward.
- check=(10-sum%10)%10.
- Match: go to HOLD. Mismatch: err 6 (CHECKSUM), go to IDLE.
- Other lengths: go to HOLD unchecked.
REQ-020 Without BARCODE_CHECKSUM_EN, no CHECK state or checksum logic SHALL exist and err 6 SHALL never occur.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- "4006381333931"+0x0D, code_ready=1 -> code_valid once; code_len=13; nibbles 4,0,0,6,3,8,1,3,3,3,9,3,1; upper nibbles none (52 bits exact).
- With macro, "4006381333932"+0x0D -> err_code=6, no code_valid; same frame ending in 1 -> code_valid 2 cycles after terminator.
- "1234567"+0x0D -> err_code=3; then "12345678"+0x0D+0x0A -> one code_valid, code_len=8, CR/LF both absorbed.
- 14 digits -> err_code=2 on the 14th; "12A"+0x0D -> err_code=1, DISCARD, IDLE after 0x0D.
- "123", then TIMEOUT_CYCLES idle clocks -> err_code=4 once; a byte sent in HOLD with code_ready=0 -> err_code=5, code_bcd unchanged.
- rst_n pulsed low mid-frame and in HOLD -> all outputs at reset values, next frame received correctly.

Source files
------------

// File: rtl/barcode_frame_ctrl.sv
// Frames ASCII barcode digits from a UART byte stream into packed BCD.
// Optional EAN check-digit verification when BARCODE_CHECKSUM_EN is defined.
module barcode_frame_ctrl #(
    parameter int MIN_DIGITS     = 8,
    parameter int MAX_DIGITS     = 13,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [51:0] code_bcd,
    output logic [3:0]  code_len,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        err_valid,
    output logic [2:0]  err_code
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] MINL = 4'(MIN_DIGITS);
    localparam logic [3:0] MAXL = 4'(MAX_DIGITS);

    localparam logic [2:0] E_BADCHAR  = 3'd1;
    localparam logic [2:0] E_OVERFLOW = 3'd2;
    localparam logic [2:0] E_SHORT    = 3'd3;
    localparam logic [2:0] E_TIMEOUT  = 3'd4;
    localparam logic [2:0] E_OVERRUN  = 3'd5;
`ifdef BARCODE_CHECKSUM_EN
    localparam logic [2:0] E_CHECKSUM = 3'd6;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef BARCODE_CHECKSUM_EN
        S_CHECK,
`endif
        S_COLLECT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [51:0]     bcd_q, bcd_d;
    logic [3:0]      len_q, len_d;
    logic            errv_q, errv_d;
    logic [2:0]      errc_q, errc_d;

    logic is_digit;
    logic is_term;
    logic tmo;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign tmo      = !rx_valid && (cnt_q == TMO_LAST);

`ifdef BARCODE_CHECKSUM_EN
    logic [9:0] sum;
    logic [3:0] par;
    logic [3:0] chk;
    logic [3:0] last;
    logic       chk_en;

    // Weight 3 lands on the digit just left of the check digit.
    always_comb begin
        sum  = '0;
        par  = '0;
        last = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (4'(i) == len_q - 4'd1) begin
                last = bcd_q[4*i +: 4];
            end
            if (4'(i) < len_q - 4'd1) begin
                par = len_q - 4'd2 - 4'(i);
                if (!par[0]) begin
                    sum = sum + 10'(bcd_q[4*i +: 4]) * 10'd3;
                end else begin
                    sum = sum + 10'(bcd_q[4*i +: 4]);
                end
            end
        end
        chk    = 4'((10'd10 - (sum % 10'd10)) % 10'd10);
        chk_en = (len_q == 4'd13) || (len_q == 4'd8);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        len_d   = len_q;
        errv_d  = 1'b0;
        errc_d  = 3'd0;

        if (rx_valid) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && is_digit) begin
                    bcd_d      = '1;
                    bcd_d[3:0] = rx_data[3:0];
                    len_d      = 4'd1;
                    state_d    = S_COLLECT;
                end else if (rx_valid && !is_term) begin
                    errv_d  = 1'b1;
                    errc_d  = E_BADCHAR;
                    state_d = S_DISCARD;
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        if (len_q == MAXL) begin
                            errv_d  = 1'b1;
                            errc_d  = E_OVERFLOW;
                            state_d = S_DISCARD;
                        end else begin
                            bcd_d[4*int'(len_q) +: 4] = rx_data[3:0];
                            len_d = len_q + 4'd1;
                        end
                    end else if (is_term) begin
                        if (len_q < MINL) begin
                            errv_d  = 1'b1;
                            errc_d  = E_SHORT;
                            state_d = S_IDLE;
                        end else begin
`ifdef BARCODE_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_HOLD;
`endif
                        end
                    end else begin
                        errv_d  = 1'b1;
                        errc_d  = E_BADCHAR;
                        state_d = S_DISCARD;
                    end
                end else if (tmo) begin
                    errv_d  = 1'b1;
                    errc_d  = E_TIMEOUT;
                    state_d = S_IDLE;
                end
            end
`ifdef BARCODE_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    errv_d = 1'b1;
                    errc_d = E_OVERRUN;
                end
                if (!chk_en || (chk == last)) begin
                    state_d = S_HOLD;
                end else begin
                    errv_d  = 1'b1;
                    errc_d  = E_CHECKSUM;
                    state_d = S_IDLE;
                end
            end
`endif
            S_HOLD: begin
                if (rx_valid) begin
                    errv_d = 1'b1;
                    errc_d = E_OVERRUN;
                end
                if (code_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if ((rx_valid && is_term) || tmo) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only an in-frame wait may accumulate idle time.
        if (state_d != S_COLLECT && state_d != S_DISCARD) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcd_q   <= '1;
            len_q   <= '0;
            errv_q  <= 1'b0;
            errc_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            len_q   <= len_d;
            errv_q  <= errv_d;
            errc_q  <= errc_d;
        end
    end

    assign code_bcd   = bcd_q;
    assign code_len   = len_q;
    assign code_valid = (state_q == S_HOLD);
    assign err_valid  = errv_q;
    assign err_code   = errc_q;

endmodule

// File: tb/tb_barcode_frame_ctrl.sv
// Bench for barcode_frame_ctrl: digit-queue reference model plus directed frames.
// Honours BARCODE_CHECKSUM_EN in the model and in the literal expectations.
module tb_barcode_frame_ctrl;
    localparam int MIN = 8;
    localparam int MAX = 13;
    localparam int TMO = 40;
`ifdef BARCODE_CHECKSUM_EN
    localparam bit CK  = 1'b1;
    localparam int LAT = 2;
`else
    localparam bit CK  = 1'b0;
    localparam int LAT = 1;
`endif
    localparam logic [51:0] ONES   = '1;
    localparam logic [51:0] EAN13  = 52'h1393331836004;
    localparam logic [51:0] DIG8   = 52'hFFFFF87654321;

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_CHECK = 2;
    localparam int M_HOLD  = 3;
    localparam int M_DROP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [51:0] code_bcd;
    logic [3:0]  code_len;
    logic        code_valid;
    logic        code_ready = 1'b1;
    logic        err_valid;
    logic [2:0]  err_code;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int term_cyc = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    logic [51:0] cap_bcd = '0;
    logic [3:0]  cap_len = '0;
    int seen_err[$];

    int m_mode = M_IDLE;
    int m_q[$];
    int m_idle = 0;
    int m_err = 0;

    barcode_frame_ctrl #(
        .MIN_DIGITS(MIN),
        .MAX_DIGITS(MAX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .code_bcd(code_bcd),
        .code_len(code_len),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .err_valid(err_valid),
        .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [51:0] pack(input int d[$]);
        logic [51:0] r;
        r = '1;
        for (int i = 0; i < d.size(); i++) r[4*i +: 4] = 4'(d[i]);
        return r;
    endfunction

    // Whole-code form: weights 1,3,1,... from the right, total divisible by 10.
    function automatic bit ean_ok(input int d[$]);
        int s;
        int n;
        s = 0;
        n = d.size();
        for (int k = 0; k < n; k++) s += d[n-1-k] * ((k % 2 == 1) ? 3 : 1);
        return (s % 10) == 0;
    endfunction

    function automatic int first_err();
        return (seen_err.size() > 0) ? seen_err[0] : 0;
    endfunction

    // Reference model
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE;
                m_q.delete();
                m_idle = 0;
                m_err = 0;
            end else begin
                automatic bit v = rx_valid;
                automatic bit dg = (rx_data >= 8'h30) && (rx_data <= 8'h39);
                automatic bit tm = (rx_data == 8'h0D) || (rx_data == 8'h0A);
                m_err = 0;
                case (m_mode)
                    M_IDLE: if (v) begin
                        m_idle = 0;
                        if (dg) begin
                            m_q.delete();
                            m_q.push_back(int'(rx_data) - 48);
                            m_mode = M_FRAME;
                        end else if (!tm) begin
                            m_err = 1;
                            m_mode = M_DROP;
                        end
                    end
                    M_FRAME: if (v) begin
                        m_idle = 0;
                        if (dg && m_q.size() == MAX) begin
                            m_err = 2;
                            m_mode = M_DROP;
                        end else if (dg) begin
                            m_q.push_back(int'(rx_data) - 48);
                        end else if (tm && m_q.size() < MIN) begin
                            m_err = 3;
                            m_mode = M_IDLE;
                        end else if (tm) begin
                            m_mode = CK ? M_CHECK : M_HOLD;
                        end else begin
                            m_err = 1;
                            m_mode = M_DROP;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            m_err = 4;
                            m_mode = M_IDLE;
                            m_idle = 0;
                        end
                    end
                    M_CHECK: begin
                        if (v) m_err = 5;
                        if ((m_q.size() == 13 || m_q.size() == 8) && !ean_ok(m_q)) begin
                            m_err = 6;
                            m_mode = M_IDLE;
                        end else begin
                            m_mode = M_HOLD;
                        end
                    end
                    M_HOLD: begin
                        if (v) m_err = 5;
                        if (code_ready) m_mode = M_IDLE;
                    end
                    default: begin
                        if (v) m_idle = 0;
                        else m_idle++;
                        if ((v && tm) || (!v && m_idle == TMO)) begin
                            m_mode = M_IDLE;
                            m_idle = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        automatic bit prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_bcd", 64'(code_bcd), 64'(ONES));
                chk("rst_len", 64'(code_len), 64'd0);
                chk("rst_valid", 64'(code_valid), 64'd0);
                chk("rst_errv", 64'(err_valid), 64'd0);
                chk("rst_errc", 64'(err_code), 64'd0);
                prev_v = 1'b0;
            end else begin
                chk("code_valid", 64'(code_valid), 64'(m_mode == M_HOLD));
                chk("err_valid", 64'(err_valid), 64'(m_err != 0));
                chk("err_code", 64'(err_code), 64'(m_err));
                if (m_mode == M_HOLD) begin
                    chk("hold_bcd", 64'(code_bcd), 64'(pack(m_q)));
                    chk("hold_len", 64'(code_len), 64'(m_q.size()));
                end
                if (err_valid) seen_err.push_back(int'(err_code));
                if (code_valid && !prev_v) begin
                    valid_cnt++;
                    cap_bcd = code_bcd;
                    cap_len = code_len;
                    valid_cyc = cyc;
                end
                prev_v = code_valid;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        if (b == 8'h0D || b == 8'h0A) term_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic new_scn();
        settle(1);
        seen_err.delete();
        valid_cnt = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        settle(2);
        chk("rstp_valid", 64'(code_valid), 64'd0);
        chk("rstp_len", 64'(code_len), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        settle(3);
        chk("init_bcd", 64'(code_bcd), 64'(ONES));
        rst_n = 1'b1;

        // Valid EAN-13 with consumer ready
        new_scn();
        send_str("4006381333931");
        send(8'h0D);
        settle(5);
        chk("s1_vcnt", 64'(valid_cnt), 64'd1);
        chk("s1_len", 64'(cap_len), 64'd13);
        chk("s1_bcd", 64'(cap_bcd), 64'(EAN13));
        chk("s1_lat", 64'(valid_cyc - term_cyc), 64'(LAT));
        chk("s1_errs", 64'(seen_err.size()), 64'd0);

`ifdef BARCODE_CHECKSUM_EN
        new_scn();
        send_str("4006381333932");
        send(8'h0D);
        settle(5);
        chk("s2_err", 64'(first_err()), 64'd6);
        chk("s2_vcnt", 64'(valid_cnt), 64'd0);
`endif

        // Too short, then an 8-digit frame followed by CR LF
        new_scn();
        send_str("1234567");
        send(8'h0D);
        settle(3);
        chk("s3_err", 64'(first_err()), 64'd3);
        chk("s3_nerr", 64'(seen_err.size()), 64'd1);
        new_scn();
        send_str("12345678");
        send(8'h0D);
        send(8'h0A);
        settle(5);
`ifdef BARCODE_CHECKSUM_EN
        chk("s3b_err", 64'(first_err()), 64'd6);
        chk("s3b_vcnt", 64'(valid_cnt), 64'd0);
`else
        chk("s3b_vcnt", 64'(valid_cnt), 64'd1);
        chk("s3b_len", 64'(cap_len), 64'd8);
        chk("s3b_bcd", 64'(cap_bcd), 64'(DIG8));
        chk("s3b_errs", 64'(seen_err.size()), 64'd0);
`endif

        // Overflow on the 14th digit, bad character, silent DISCARD timeout
        new_scn();
        send_str("12345678901234");
        settle(2);
        chk("s4_err", 64'(first_err()), 64'd2);
        send(8'h0D);
        new_scn();
        send_str("12A");
        send(8'h0D);
        settle(2);
        chk("s4b_err", 64'(first_err()), 64'd1);
        chk("s4b_nerr", 64'(seen_err.size()), 64'd1);
        new_scn();
        send_str("X");
        settle(TMO + 5);
        chk("s4c_nerr", 64'(seen_err.size()), 64'd1);
        new_scn();
        send_str("4006381333931");
        send(8'h0D);
        settle(5);
        chk("s4d_vcnt", 64'(valid_cnt), 64'd1);
        chk("s4d_errs", 64'(seen_err.size()), 64'd0);

        // In-frame timeout
        new_scn();
        send_str("123");
        settle(TMO + 10);
        chk("s5_err", 64'(first_err()), 64'd4);
        chk("s5_nerr", 64'(seen_err.size()), 64'd1);

        // Overrun while holding with consumer stalled
        new_scn();
        code_ready = 1'b0;
        send_str("4006381333931");
        send(8'h0D);
        settle(3);
        send(8'h35);
        settle(3);
        chk("s6_err", 64'(first_err()), 64'd5);
        chk("s6_bcd", 64'(code_bcd), 64'(EAN13));
        chk("s6_valid", 64'(code_valid), 64'd1);
        code_ready = 1'b1;
        settle(2);
        chk("s6_vcnt", 64'(valid_cnt), 64'd1);
        chk("s6_drop", 64'(code_valid), 64'd0);

        // Reset mid-frame, then in HOLD
        new_scn();
        send_str("1234");
        pulse_reset();
        settle(3);
        chk("s7_errs", 64'(seen_err.size()), 64'd0);
        send_str("4006381333931");
        send(8'h0D);
        settle(5);
        chk("s7_vcnt", 64'(valid_cnt), 64'd1);
        chk("s7_bcd", 64'(cap_bcd), 64'(EAN13));
        new_scn();
        code_ready = 1'b0;
        send_str("4006381333931");
        send(8'h0D);
        settle(3);
        chk("s8_hold", 64'(code_valid), 64'd1);
        pulse_reset();
        code_ready = 1'b1;
        settle(3);
        chk("s8_errs", 64'(seen_err.size()), 64'd0);
        chk("s8_bcd", 64'(code_bcd), 64'(ONES));
        new_scn();
        send_str("4006381333931");
        send(8'h0D);
        settle(5);
        chk("s8_vcnt", 64'(valid_cnt), 64'd1);
        chk("s8_len", 64'(cap_len), 64'd13);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
